// File: rtl/reg_bus_latency_injector.sv
// Register-bus latency injector: buffers one request, holds it for a fixed
// number of cycles, forwards it downstream and returns the captured response.
// A downstream-hang timeout turns a stuck access into an error response.
module reg_bus_latency_injector #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Latency   = 4,
  parameter int unsigned Timeout   = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   slv_valid_i,
  output logic                   slv_ready_o,
  input  logic                   slv_write_i,
  input  logic [AddrWidth-1:0]   slv_addr_i,
  input  logic [DataWidth-1:0]   slv_wdata_i,
  input  logic [DataWidth/8-1:0] slv_wstrb_i,
  output logic [DataWidth-1:0]   slv_rdata_o,
  output logic                   slv_error_o,
  output logic                   mst_valid_o,
  input  logic                   mst_ready_i,
  output logic                   mst_write_o,
  output logic [AddrWidth-1:0]   mst_addr_o,
  output logic [DataWidth-1:0]   mst_wdata_o,
  output logic [DataWidth/8-1:0] mst_wstrb_o,
  input  logic [DataWidth-1:0]   mst_rdata_i,
  input  logic                   mst_error_i,
  output logic [31:0]            txn_count_o,
  output logic                   timeout_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned LatW      = (Latency > 0) ? $clog2(Latency + 1) : 1;
  localparam int unsigned TimW      = (Timeout > 0) ? $clog2(Timeout + 1) : 1;
  localparam bit          HasLat    = (Latency > 0);
  localparam bit          HasTo     = (Timeout > 0);

  localparam logic [LatW-1:0] LatInit = LatW'(Latency);
  localparam logic [TimW-1:0] TimLast = TimW'((Timeout > 0) ? Timeout - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]           r_state;
  logic [LatW-1:0]      r_lat_cnt;
  logic [TimW-1:0]      r_tim_cnt;
  logic                 r_write;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata;
  logic [StrbWidth-1:0] r_wstrb;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_error;
  logic                 r_slv_ready;
  logic                 r_mst_valid;
  logic [31:0]          r_txn_cnt;
  logic                 r_timeout;

  logic [1:0]           w_state_nxt;
  logic [LatW-1:0]      w_lat_nxt;
  logic [TimW-1:0]      w_tim_nxt;
  logic                 w_load;
  logic                 w_done_ok;
  logic                 w_done_to;

  // Next-state logic: accept, count down latency, issue with hang guard, respond.
  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat_cnt;
    w_tim_nxt   = r_tim_cnt;
    w_load      = 1'b0;
    w_done_ok   = 1'b0;
    w_done_to   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (slv_valid_i) begin
          w_load      = 1'b1;
          w_lat_nxt   = LatInit;
          w_tim_nxt   = '0;
          w_state_nxt = HasLat ? S_WAIT : S_ISSUE;
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == LatW'(1)) begin
          w_tim_nxt   = '0;
          w_state_nxt = S_ISSUE;
        end else begin
          w_lat_nxt = r_lat_cnt - LatW'(1);
        end
      end
      S_ISSUE: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (mst_ready_i) begin
          w_done_ok   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (HasTo && (r_tim_cnt == TimLast)) begin
          w_done_to   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (HasTo) begin
          w_tim_nxt = r_tim_cnt + TimW'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
      r_tim_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_tim_cnt <= w_tim_nxt;
    end
  end

  // Request buffer, captured response and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rdata     <= '0;
      r_error     <= 1'b0;
      r_slv_ready <= 1'b0;
      r_mst_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_write <= slv_write_i;
        r_addr  <= slv_addr_i;
        r_wdata <= slv_wdata_i;
        r_wstrb <= slv_wstrb_i;
      end
      r_mst_valid <= (w_state_nxt == S_ISSUE);
      r_slv_ready <= (w_state_nxt == S_RESP);
      if (w_done_ok) begin
        r_rdata <= r_write ? '0 : mst_rdata_i;
        r_error <= mst_error_i;
      end else if (w_done_to) begin
        r_rdata <= '0;
        r_error <= 1'b1;
      end else if (r_state == S_RESP) begin
        r_rdata <= '0;
        r_error <= 1'b0;
      end
    end
  end

  // Completed-transaction counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_txn_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_done_ok || w_done_to) begin
        r_txn_cnt <= r_txn_cnt + 32'd1;
      end
      if (w_done_to) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign slv_ready_o = r_slv_ready;
  assign slv_rdata_o = r_rdata;
  assign slv_error_o = r_error;
  assign mst_valid_o = r_mst_valid;
  assign mst_write_o = r_write;
  assign mst_addr_o  = r_addr;
  assign mst_wdata_o = r_wdata;
  assign mst_wstrb_o = r_wstrb;
  assign txn_count_o = r_txn_cnt;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_reg_bus_latency_injector.sv
// Scoreboard bench for reg_bus_latency_injector: two instances (Latency 4 with
// Timeout 16, and Latency 0 with no timeout) behind a scheduled-ready responder.
module tb_reg_bus_latency_injector;

  localparam int unsigned LA = 4;
  localparam int unsigned TA = 16;
  localparam int unsigned LB = 0;

  typedef struct {
    int unsigned cyc;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  bit          cur_sel = 1'b0;

  logic        a_valid, a_write, a_slv_ready, a_error, a_mst_valid, a_mst_rdy, a_mst_write, a_mst_err, a_to;
  logic [31:0] a_addr, a_mst_addr, a_cnt;
  logic [63:0] a_wdata, a_rdata, a_mst_wdata, a_mst_rdata;
  logic [7:0]  a_wstrb, a_mst_wstrb;
  int unsigned a_rdy_at = 0;

  logic        b_valid, b_write, b_slv_ready, b_error, b_mst_valid, b_mst_rdy, b_mst_write, b_mst_err, b_to;
  logic [31:0] b_addr, b_mst_addr, b_cnt;
  logic [63:0] b_wdata, b_rdata, b_mst_wdata, b_mst_rdata;
  logic [7:0]  b_wstrb, b_mst_wstrb;
  int unsigned b_rdy_at = 0;

  logic        m_slv_ready, m_mst_valid, m_mst_write, m_error;
  logic [31:0] m_mst_addr;
  logic [63:0] m_mst_wdata, m_rdata;
  logic [7:0]  m_mst_wstrb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: read data derived from the address; ready follows a schedule.
  assign a_mst_rdata = {a_mst_addr, ~a_mst_addr};
  assign b_mst_rdata = {b_mst_addr, ~b_mst_addr};
  always @(negedge clk) begin
    a_mst_rdy = (cyc >= a_rdy_at);
    b_mst_rdy = (cyc >= b_rdy_at);
  end

  assign m_slv_ready = cur_sel ? b_slv_ready : a_slv_ready;
  assign m_mst_valid = cur_sel ? b_mst_valid : a_mst_valid;
  assign m_mst_write = cur_sel ? b_mst_write : a_mst_write;
  assign m_mst_addr  = cur_sel ? b_mst_addr  : a_mst_addr;
  assign m_mst_wdata = cur_sel ? b_mst_wdata : a_mst_wdata;
  assign m_mst_wstrb = cur_sel ? b_mst_wstrb : a_mst_wstrb;
  assign m_rdata     = cur_sel ? b_rdata     : a_rdata;
  assign m_error     = cur_sel ? b_error     : a_error;

  reg_bus_latency_injector #(.AddrWidth(32), .DataWidth(64), .Latency(LA), .Timeout(TA)) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_valid_i(a_valid), .slv_ready_o(a_slv_ready), .slv_write_i(a_write),
    .slv_addr_i(a_addr), .slv_wdata_i(a_wdata), .slv_wstrb_i(a_wstrb),
    .slv_rdata_o(a_rdata), .slv_error_o(a_error),
    .mst_valid_o(a_mst_valid), .mst_ready_i(a_mst_rdy), .mst_write_o(a_mst_write),
    .mst_addr_o(a_mst_addr), .mst_wdata_o(a_mst_wdata), .mst_wstrb_o(a_mst_wstrb),
    .mst_rdata_i(a_mst_rdata), .mst_error_i(a_mst_err),
    .txn_count_o(a_cnt), .timeout_o(a_to)
  );

  reg_bus_latency_injector #(.AddrWidth(32), .DataWidth(64), .Latency(LB), .Timeout(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_valid_i(b_valid), .slv_ready_o(b_slv_ready), .slv_write_i(b_write),
    .slv_addr_i(b_addr), .slv_wdata_i(b_wdata), .slv_wstrb_i(b_wstrb),
    .slv_rdata_o(b_rdata), .slv_error_o(b_error),
    .mst_valid_o(b_mst_valid), .mst_ready_i(b_mst_rdy), .mst_write_o(b_mst_write),
    .mst_addr_o(b_mst_addr), .mst_wdata_o(b_mst_wdata), .mst_wstrb_o(b_mst_wstrb),
    .mst_rdata_i(b_mst_rdata), .mst_error_i(b_mst_err),
    .txn_count_o(b_cnt), .timeout_o(b_to)
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Scoreboard monitors: pop and compare on every upstream response pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && a_slv_ready === 1'b1) begin
      if (qa.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL a_unexpected_resp: got response expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_resp_cycle", 64'(cyc), 64'(e.cyc));
        chk("a_rdata", a_rdata, e.rdata);
        chk("a_error", 64'(a_error), 64'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && b_slv_ready === 1'b1) begin
      if (qb.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL b_unexpected_resp: got response expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_resp_cycle", 64'(cyc), 64'(e.cyc));
        chk("b_rdata", b_rdata, e.rdata);
        chk("b_error", 64'(b_error), 64'(e.err));
      end
    end
  end

  // One request; stall<0 means downstream never answers (timeout path).
  task automatic req(input bit sel, input logic wr, input logic [31:0] addr,
                     input logic [63:0] wdata, input logic [7:0] wstrb,
                     input int stall, input logic err, input bit early);
    int unsigned t;
    int unsigned lat;
    int unsigned rdy_at;
    exp_t        e;
    bit          done;
    lat = sel ? LB : LA;
    cur_sel = sel;
    @(negedge clk);
    t = cyc;
    rdy_at = (stall < 0) ? 32'hFFFF_FFFF : t + lat + 1 + int'(stall);
    if (sel) begin
      b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = wdata; b_wstrb = wstrb;
      b_mst_err = err; b_rdy_at = rdy_at;
    end else begin
      a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb;
      a_mst_err = err; a_rdy_at = rdy_at;
    end
    e.cyc   = (stall < 0) ? t + lat + 1 + TA : t + lat + 2 + int'(stall);
    e.rdata = (wr || stall < 0) ? 64'h0 : {addr, ~addr};
    e.err   = (stall < 0) ? 1'b1 : err;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
    done = 1'b0;
    for (int k = 1; k < 200 && !done; k++) begin
      @(negedge clk);
      if (lat > 0 && k == int'(lat)) chk("mst_valid_before_issue", 64'(m_mst_valid), 64'h0);
      if (k == int'(lat) + 1) begin
        chk("mst_valid_issue", 64'(m_mst_valid), 64'h1);
        chk("mst_write", 64'(m_mst_write), 64'(wr));
        chk("mst_addr", 64'(m_mst_addr), 64'(addr));
        chk("mst_wdata", m_mst_wdata, wdata);
        chk("mst_wstrb", 64'(m_mst_wstrb), 64'(wstrb));
      end
      if (stall < 0 && k == int'(lat + TA)) chk("mst_valid_last_issue", 64'(m_mst_valid), 64'h1);
      if (early && k == 1) begin
        if (sel) begin b_valid = 1'b0; b_addr = ~addr; end
        else     begin a_valid = 1'b0; a_addr = ~addr; end
      end
      if (m_slv_ready === 1'b1) begin
        done = 1'b1;
        chk("mst_valid_in_resp", 64'(m_mst_valid), 64'h0);
        if (sel) b_valid = 1'b0;
        else     a_valid = 1'b0;
      end
    end
    if (!done) begin
      n_assert++;
      n_fail++;
      $display("FAIL req_no_response: got no ready expected one at cycle %0d", e.cyc);
      if (sel) begin b_valid = 1'b0; void'(qb.pop_back()); end
      else     begin a_valid = 1'b0; void'(qa.pop_back()); end
    end
    @(negedge clk);
    chk("rdata_after_resp", m_rdata, 64'h0);
    chk("error_after_resp", 64'(m_error), 64'h0);
  endtask

  initial begin
    int unsigned t;
    exp_t        e;
    a_valid = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_wstrb = 0; a_mst_err = 0;
    b_valid = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_wstrb = 0; b_mst_err = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_slv_ready", 64'(a_slv_ready), 64'h0);
    chk("rst_a_mst_valid", 64'(a_mst_valid), 64'h0);
    chk("rst_a_cnt", 64'(a_cnt), 64'h0);
    chk("rst_a_timeout", 64'(a_to), 64'h0);
    chk("rst_a_mst_addr", 64'(a_mst_addr), 64'h0);
    chk("rst_b_mst_valid", 64'(b_mst_valid), 64'h0);
    rst_n = 1'b1;

    // Latency 4, immediate ready.
    req(1'b0, 1'b0, 32'h8000_0000, 64'h0, 8'h00, 0, 1'b0, 1'b0);
    chk("a_cnt_first", 64'(a_cnt), 64'h1);
    // Three stall cycles with downstream error.
    req(1'b0, 1'b0, 32'h1234_5678, 64'h0, 8'h00, 3, 1'b1, 1'b0);
    chk("a_timeout_after_err", 64'(a_to), 64'h0);
    // Ready arrives on the same cycle the timeout would fire: ready wins.
    req(1'b0, 1'b1, 32'h0000_0040, 64'h0000_CAFE, 8'h0F, int'(TA) - 1, 1'b0, 1'b0);
    chk("a_timeout_ready_wins", 64'(a_to), 64'h0);
    // Downstream hangs: timeout error response.
    req(1'b0, 1'b0, 32'h0000_0100, 64'h0, 8'h00, -1, 1'b0, 1'b0);
    chk("a_timeout_set", 64'(a_to), 64'h1);
    // Upstream drops valid early; buffered request still completes.
    req(1'b0, 1'b0, 32'h0000_0200, 64'h0, 8'h00, 0, 1'b0, 1'b1);
    chk("a_timeout_sticky", 64'(a_to), 64'h1);
    chk("a_cnt_five", 64'(a_cnt), 64'h5);

    // Latency 0 write and a long-stalled read with no timeout.
    req(1'b1, 1'b1, 32'h0000_0010, 64'h11, 8'h01, 0, 1'b0, 1'b0);
    req(1'b1, 1'b0, 32'h0000_0020, 64'h0, 8'h00, 40, 1'b0, 1'b0);
    chk("b_cnt", 64'(b_cnt), 64'h2);
    chk("b_timeout", 64'(b_to), 64'h0);

    // Reset during the WAIT phase abandons the request.
    cur_sel = 1'b0;
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b0; a_addr = 32'h0000_0300; a_rdy_at = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    a_valid = 1'b0;
    chk("rstw_slv_ready", 64'(a_slv_ready), 64'h0);
    chk("rstw_mst_valid", 64'(a_mst_valid), 64'h0);
    chk("rstw_cnt", 64'(a_cnt), 64'h0);
    chk("rstw_timeout", 64'(a_to), 64'h0);
    chk("rstw_mst_addr", 64'(a_mst_addr), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req(1'b0, 1'b0, 32'h0000_0400, 64'h0, 8'h00, 0, 1'b0, 1'b0);
    chk("a_cnt_after_reset", 64'(a_cnt), 64'h1);

    // Back-to-back: 100 reads with valid held continuously.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t = cyc;
    a_valid = 1'b1; a_write = 1'b0; a_addr = 32'hA000_0000; a_mst_err = 1'b0; a_rdy_at = 0;
    for (int i = 0; i < 100; i++) begin
      e.cyc   = t + LA + 2 + (LA + 3) * i;
      e.rdata = {32'hA000_0000, ~32'hA000_0000};
      e.err   = 1'b0;
      qa.push_back(e);
    end
    repeat ((LA + 3) * 99 + 1) @(negedge clk);
    a_valid = 1'b0;
    for (int k = 0; k < 50 && qa.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("a_b2b_drained", 64'(qa.size()), 64'h0);
    chk("a_cnt_hundred", 64'(a_cnt), 64'd100);

    // Counter wrap.
    force u_a.r_txn_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release u_a.r_txn_cnt;
    chk("a_cnt_forced", 64'(a_cnt), 64'hFFFF_FFFF);
    req(1'b0, 1'b0, 32'h0000_0500, 64'h0, 8'h00, 0, 1'b0, 1'b0);
    chk("a_cnt_wrap", 64'(a_cnt), 64'h0);

    repeat (3) @(negedge clk);
    chk("qa_empty", 64'(qa.size()), 64'h0);
    chk("qb_empty", 64'(qb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bus_latency_injector.md
Name: reg_bus_latency_injector

Overview:
- Register-bus stage between the AXI-to-register converter and the DPI-backed testbench memory responder.
- Buffers one request, delays it by a programmable number of cycles, forwards it downstream and returns the captured response upstream.
- Lets benches model slow off-cluster memory without touching the memory model.
- Includes a downstream-hang timeout that converts a stuck access into an error response instead of a silent simulation hang.

Parameters:
- AddrWidth, 32, address width of both register-bus sides.
- DataWidth, 64, data width; strobe width is DataWidth/8.
- Latency, 4, wait cycles inserted before issuing downstream; 0 allowed.
- Timeout, 1024, max cycles waiting for downstream ready; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- slv_valid_i  in  1  upstream request valid.
- slv_ready_o  out  1  upstream response strobe; rdata/error valid while high.
- slv_write_i  in  1  upstream write (1) / read (0).
- slv_addr_i  in  AddrWidth  upstream address.
- slv_wdata_i  in  DataWidth  upstream write data.
- slv_wstrb_i  in  DataWidth/8  upstream byte strobes.
- slv_rdata_o  out  DataWidth  upstream read data.
- slv_error_o  out  1  upstream error.
- mst_valid_o  out  1  downstream request valid.
- mst_ready_i  in  1  downstream ready.
- mst_write_o  out  1  downstream write.
- mst_addr_o  out  AddrWidth  downstream address.
- mst_wdata_o  out  DataWidth  downstream write data.
- mst_wstrb_o  out  DataWidth/8  downstream strobes.
- mst_rdata_i  in  DataWidth  downstream read data.
- mst_error_i  in  1  downstream error.
- txn_count_o  out  32  completed transactions, wraps 0xFFFFFFFF->0.
- timeout_o  out  1  sticky: set on any timeout, cleared only by reset.

Behaviour:
- Clock clk_i, reset rst_ni asynchronous active-low.
- Reset: state IDLE, all outputs 0, request/response registers 0, counters 0. Reset mid-transaction abandons it; no response is returned.
- States: IDLE, WAIT, ISSUE, RESP.
- IDLE:
  - slv_ready_o=0, mst_valid_o=0.
  - On slv_valid_i: register write/addr/wdata/wstrb, load wait counter with Latency.
  - Go to WAIT if Latency>0, else ISSUE.
- WAIT: decrement each cycle; after exactly Latency cycles in WAIT, go to ISSUE.
- ISSUE:
  - mst_valid_o=1; mst_* driven only from the registered copy, never combinationally from slv_*.
  - On mst_ready_i: capture mst_rdata_i (forced to 0 for writes) and mst_error_i, go to RESP.
  - Timeout counter clears on ISSUE entry. If Timeout>0 and the counter reaches Timeout with no ready: capture rdata=0, error=1, set timeout_o, go to RESP.
  - mst_valid_o drops on a timeout; this downstream protocol break is accepted in benches only.
- RESP:
  - slv_ready_o=1 for exactly one cycle with the registered rdata/error.
  - txn_count_o increments (timeouts included).
  - Next state IDLE. A new request is accepted no earlier than the following cycle (at most one outstanding).
- Latency with immediate downstream ready: request seen at cycle 0 gives slv_ready_o at cycle Latency+2. Each downstream stall cycle adds one.
- Upstream protocol: slv_valid_i must hold until slv_ready_o. If it drops early, the buffered transaction still completes downstream and RESP still pulses ready; the response is discarded.
- slv_rdata_o/slv_error_o are 0 outside RESP.
- Simultaneous timeout-reach and mst_ready_i in the same cycle: ready wins; no error, timeout_o unchanged.
- Latency and Timeout are elaboration-time only; counters are sized $clog2(max+1), minimum 1 bit.

Test Plan:
- Latency=4, read addr 0x8000_0000, mst_ready_i tied 1, mst_rdata_i=0xDEAD_BEEF_0123_4567 -> mst_valid_o at cycle 5; slv_ready_o at cycle 6 with that rdata, error=0; txn_count_o=1.
- Latency=0, write wdata=0x11, wstrb=0x01 -> mst_valid_o at cycle 1 with matching registered fields; slv_ready_o at cycle 2; slv_rdata_o=0.
- Latency=2, downstream ready delayed 3 cycles, mst_error_i=1 -> slv_ready_o at cycle 7, slv_error_o=1, timeout_o=0.
- Timeout=16, mst_ready_i held 0 -> after 16 ISSUE cycles mst_valid_o=0; next cycle slv_ready_o=1, error=1, rdata=0; timeout_o=1 and stays 1 through the next good transaction.
- Assert rst_ni low during WAIT of a request -> all outputs 0 immediately; after release, a new request completes normally with txn_count_o=1.
- Back-to-back: 100 reads with slv_valid_i held continuously -> each completes in Latency+3 cycles including the IDLE cycle; txn_count_o=100. Also force the counter to 0xFFFFFFFF -> one more transaction wraps it to 0.
